// File: rtl/ram_dp_sync.sv
// Dual-port synchronous RAM: port A read/write, port B read-only with valid strobe.
// Optional post-reset clear engine enabled by defining RAM_DP_CLEAR_EN.
module ram_dp_sync #(
    parameter int          DATA_WIDTH = 8,
    parameter int          ADDR_WIDTH = 11,
    parameter logic [63:0] INIT_VALUE = '0,
    parameter int          RDW_MODE   = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    input  logic [DATA_WIDTH-1:0] i_a_data,
    input  logic                  i_a_w_n,
    output logic [DATA_WIDTH-1:0] o_a_q,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    input  logic                  i_b_rd,
    output logic [DATA_WIDTH-1:0] o_b_q,
    output logic                  o_b_valid,
    output logic                  o_busy
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam bit WRITE_THROUGH = (RDW_MODE == 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  busy;
    logic [DATA_WIDTH-1:0] a_word;
    logic [DATA_WIDTH-1:0] b_word;

`ifdef RAM_DP_CLEAR_EN
    localparam logic [DATA_WIDTH-1:0] INIT_WORD = INIT_VALUE[DATA_WIDTH-1:0];
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_WIDTH:0] clr_cnt;
    logic [ADDR_WIDTH:0] clr_cnt_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // Extra counter bit flags the pass over the last index without wrapping.
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        if (state == CLEAR) begin
            clr_cnt_next = clr_cnt + CNT_ONE;
            if (clr_cnt_next[ADDR_WIDTH])
                state_next = IDLE;
        end
    end

    assign busy = (state == CLEAR);

    always_ff @(posedge i_clk) begin
        if (busy)
            mem[clr_cnt[ADDR_WIDTH-1:0]] <= INIT_WORD;
        else if (!i_a_w_n)
            mem[i_a_addr] <= i_a_data;
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge i_clk) begin
        if (!i_a_w_n)
            mem[i_a_addr] <= i_a_data;
    end
`endif

    assign o_busy = busy;

    always_comb begin
        a_word = mem[i_a_addr];
        b_word = mem[i_b_addr];
        if (WRITE_THROUGH && !i_a_w_n) begin
            a_word = i_a_data;
            if (i_a_addr == i_b_addr)
                b_word = i_a_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_a_q     <= '0;
            o_b_q     <= '0;
            o_b_valid <= 1'b0;
        end else begin
            o_b_valid <= 1'b0;
            if (!busy) begin
                o_a_q <= a_word;
                if (i_b_rd) begin
                    o_b_q     <= b_word;
                    o_b_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_dp_sync.sv
// Directed self-checking bench for ram_dp_sync; one instance per read-during-write mode.
// Covers the clear-engine tests when RAM_DP_CLEAR_EN is defined.
module tb_ram_dp_sync;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          a_w_n;
    logic [AW-1:0] b_addr;
    logic          b_rd;

    logic [DW-1:0] a_q0, b_q0, a_q1, b_q1;
    logic          b_valid0, b_valid1, busy0, busy1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_dp_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(64'hA5), .RDW_MODE(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_a_addr(a_addr), .i_a_data(a_data), .i_a_w_n(a_w_n), .o_a_q(a_q0),
        .i_b_addr(b_addr), .i_b_rd(b_rd), .o_b_q(b_q0), .o_b_valid(b_valid0),
        .o_busy(busy0)
    );

    ram_dp_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(64'hA5), .RDW_MODE(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_a_addr(a_addr), .i_a_data(a_data), .i_a_w_n(a_w_n), .o_a_q(a_q1),
        .i_b_addr(b_addr), .i_b_rd(b_rd), .o_b_q(b_q1), .o_b_valid(b_valid1),
        .o_busy(busy1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_w_n  = 1'b1;
        b_rd   = 1'b0;
        a_addr = '0;
        b_addr = '0;
        a_data = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        a_addr = addr;
        a_data = data;
        a_w_n  = 1'b0;
        b_rd   = 1'b0;
        tick();
        a_w_n  = 1'b1;
    endtask

    task automatic wait_busy_low(output int n);
        n = 0;
        while ((busy0 === 1'b1) && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int vbad;

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check("rst_a_q0", a_q0, 0);
        check("rst_b_q1", b_q1, 0);
        check("rst_b_valid", {b_valid1, b_valid0}, 0);
`ifdef RAM_DP_CLEAR_EN
        check("rst_busy", {busy1, busy0}, 2'b11);

        // Lockout: write and read attempts during the whole clear.
        rst    = 1'b0;
        a_addr = 4'd2;
        a_data = 8'h3C;
        a_w_n  = 1'b0;
        b_addr = 4'd2;
        b_rd   = 1'b1;
        n      = 0;
        vbad   = 0;
        while ((busy0 === 1'b1) && n < 40) begin
            tick();
            n++;
            if (b_valid0 !== 1'b0 || b_valid1 !== 1'b0) vbad++;
        end
        idle_inputs();
        check("busy_len", n, 16);
        check("busy1_low", busy1, 0);
        check("lock_valid", vbad, 0);
        check("lock_a_hold", a_q0, 0);

        for (int i = 0; i < 16; i++) begin
            b_addr = AW'(i);
            b_rd   = 1'b1;
            tick();
            check($sformatf("clr_b_q0_%0d", i), b_q0, 8'hA5);
            check($sformatf("clr_b_valid_%0d", i), {b_valid1, b_valid0}, 2'b11);
        end
        b_rd = 1'b0;
        tick();
        check("clr_valid_drop", b_valid0, 0);
        check("clr_b_hold", b_q0, 8'hA5);
`else
        check("rst_busy", {busy1, busy0}, 2'b00);
        rst = 1'b0;
        do_write(4'd3, 8'h5A);
        a_addr = 4'd3;
        b_addr = 4'd3;
        b_rd   = 1'b1;
        tick();
        check("first_a_q0", a_q0, 8'h5A);
        check("first_b_q1", b_q1, 8'h5A);
        check("first_valid", {b_valid1, b_valid0}, 2'b11);
        check("first_busy", {busy1, busy0}, 2'b00);
        idle_inputs();
        tick();
`endif

        // Write then read on both ports.
        do_write(4'd7, 8'h11);
        a_addr = 4'd7;
        b_addr = 4'd7;
        b_rd   = 1'b1;
        tick();
        check("wr_a_q0", a_q0, 8'h11);
        check("wr_a_q1", a_q1, 8'h11);
        check("wr_b_q0", b_q0, 8'h11);
        check("wr_b_q1", b_q1, 8'h11);
        check("wr_valid", {b_valid1, b_valid0}, 2'b11);
        b_addr = 4'd7;
        tick();
        check("wr_valid_again", b_valid0, 1);
        b_rd = 1'b0;
        tick();
        check("valid_drop", {b_valid1, b_valid0}, 2'b00);
        check("b_hold", b_q0, 8'h11);

        // Same-address collision on both ports.
        do_write(4'd9, 8'h22);
        a_addr = 4'd9;
        a_data = 8'h33;
        a_w_n  = 1'b0;
        b_addr = 4'd9;
        b_rd   = 1'b1;
        tick();
        check("col_b_q0", b_q0, 8'h22);
        check("col_a_q0", a_q0, 8'h22);
        check("col_b_q1", b_q1, 8'h33);
        check("col_a_q1", a_q1, 8'h33);
        a_w_n = 1'b1;
        tick();
        check("col_after_b_q0", b_q0, 8'h33);
        check("col_after_a_q0", a_q0, 8'h33);

        // Different-address write must not forward into port B.
        a_addr = 4'd10;
        a_data = 8'h44;
        a_w_n  = 1'b0;
        b_addr = 4'd9;
        b_rd   = 1'b1;
        tick();
        check("nocol_b_q1", b_q1, 8'h33);
        check("nocol_a_q1", a_q1, 8'h44);
        a_w_n  = 1'b1;
        b_addr = 4'd10;
        tick();
        check("nocol_rd_b_q0", b_q0, 8'h44);
        idle_inputs();
        tick();

`ifdef RAM_DP_CLEAR_EN
        // Reset mid-clear restarts from index 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid_busy", busy0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_busy_low(n);
        check("mid_busy_len", n, 16);
        for (int i = 0; i < 16; i++) begin
            a_addr = AW'(i);
            tick();
            check($sformatf("mid_a_q0_%0d", i), a_q0, 8'hA5);
        end
        check("mid_a_q1", a_q1, 8'hA5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_dp_sync.md
# ram_dp_sync

Parametrised dual-port synchronous RAM, the successor to the single-port behavioural RAM used in device-manager benches (CHR/PRG stores). Port A is read/write. Port B is read-only with a valid strobe. Both read paths are registered, and read-during-write behaviour is defined per parameter. An optional clear engine fills every word with a known value after reset, so benches and loaders no longer depend on random power-up contents.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits (1..64).
- ADDR_WIDTH, 11, address width; depth = 2^ADDR_WIDTH words (1..16).
- INIT_VALUE, 0, word written by the clear engine; truncated to DATA_WIDTH.
- RDW_MODE, 0, read-during-write result on either port:
  - 0 = old data.
  - 1 = new data (write-through).

Ports:
- i_clk, in, 1, single clock; all logic on its rising edge.
- i_rst, in, 1, reset, synchronous and active-high.
- i_a_addr, in, ADDR_WIDTH, port A address.
- i_a_data, in, DATA_WIDTH, port A write data.
- i_a_w_n, in, 1, port A write enable, active-low.
- o_a_q, out, DATA_WIDTH, port A registered read data.
- i_b_addr, in, ADDR_WIDTH, port B address.
- i_b_rd, in, 1, port B read request.
- o_b_q, out, DATA_WIDTH, port B registered read data; holds last value when no read is issued.
- o_b_valid, out, 1, high for one cycle when o_b_q carries the data for a request.
- o_busy, out, 1, clear engine active; both ports are locked out while high.

## Operation
- Memory array: 2^ADDR_WIDTH × DATA_WIDTH, all indices reachable, no address wrap logic needed.
- Port A read and write:
  - Every non-busy cycle, o_a_q <= mem[i_a_addr].
  - If i_a_w_n = 0, mem[i_a_addr] <= i_a_data.
  - Same-cycle read of the written address returns old data if RDW_MODE = 0, i_a_data if RDW_MODE = 1.
- Port B read:
  - On a non-busy cycle with i_b_rd = 1, o_b_q <= mem[i_b_addr] and o_b_valid <= 1.
  - Otherwise o_b_valid <= 0 and o_b_q holds.
- Cross-port collision: when port A writes address X and port B reads X in the same cycle, port B follows RDW_MODE (old data for 0, i_a_data for 1).
- Clear engine states: IDLE and CLEAR.
  - i_rst forces CLEAR with counter = 0.
  - In CLEAR, each cycle writes INIT_VALUE to mem[counter] and increments counter.
  - After writing index 2^ADDR_WIDTH−1, the engine moves to IDLE.
  - The counter is ADDR_WIDTH+1 bits, so the terminal index is detected without wrap.
- While busy:
  - Port A writes are dropped.
  - i_b_rd is ignored (no o_b_valid).
  - o_a_q holds its value.
- Reset mid-clear restarts the clear from index 0.

## Timing
- Reset values: o_a_q = 0, o_b_q = 0, o_b_valid = 0, o_busy = 1 (clear engine compiled in) or 0 (compiled out).
- Read latency is 1 cycle on both ports: address sampled at edge N, data valid after edge N.
- Write takes effect at the edge; a read of the same address at edge N+1 or later returns the new data regardless of RDW_MODE.
- o_busy stays high during reset and for exactly 2^ADDR_WIDTH cycles after the first edge with i_rst = 0. It falls on the edge after the last clear write.
- Port operations are accepted from the first cycle in which o_busy is sampled low.
- o_b_valid is never high for two consecutive cycles unless i_b_rd is high on consecutive cycles.

## Configuration
- Macro: RAM_DP_CLEAR_EN.
- Defined:
  - The clear engine is present and runs after every reset.
  - o_busy behaves as above.
  - Memory contents after clear are all INIT_VALUE.
- Undefined:
  - No clear engine and no counter; o_busy is tied 0.
  - Ports are usable on the first cycle after reset.
  - Contents are uninitialised: X in simulation, with no $random fill.
  - Reset clears only the output registers.

## Test plan
- Clear (macro on, ADDR_WIDTH = 4, INIT_VALUE = 8'hA5): release reset → o_busy high for exactly 16 cycles; then port B reads of all 16 addresses return 8'hA5, each with o_b_valid one cycle later.
- Lockout (macro on): during busy, write 8'h3C to addr 2 and pulse i_b_rd → o_b_valid stays 0; after clear, addr 2 reads 8'hA5.
- Write/read: write 8'h11 to addr 7 → port A read of addr 7 next cycle gives 8'h11; port B read of addr 7 gives 8'h11 with o_b_valid.
- Collision, RDW_MODE = 0 vs 1: addr 9 holds 8'h22; same cycle A writes 8'h33 to addr 9 and B reads addr 9 → o_b_q = 8'h22 (mode 0) or 8'h33 (mode 1); o_a_q matches.
- Reset mid-clear: assert i_rst at clear index 5 for 1 cycle → o_busy stays high a further full 16 cycles after release, and all words equal INIT_VALUE.
- Macro off: after reset o_busy = 0, o_a_q = 0, o_b_valid = 0; write then read round-trips on the first cycle after reset.
